// File: rtl/openhmc_rf_arbiter_if.sv
// Register-file side bus of the openHMC RF arbiter.
// The master modport is the arbiter; the slave modport is the register file.
interface openhmc_rf_arbiter_if #(
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned WWIDTH = 64,
  parameter int unsigned RWIDTH = 64
);
  logic [AWIDTH-1:0] rf_address;
  logic [WWIDTH-1:0] rf_write_data;
  logic              rf_read_en;
  logic              rf_write_en;
  logic [RWIDTH-1:0] rf_read_data;
  logic              rf_access_complete;
  logic              rf_invalid_address;

  modport master (
    output rf_address, rf_write_data, rf_read_en, rf_write_en,
    input  rf_read_data, rf_access_complete, rf_invalid_address
  );

  modport slave (
    input  rf_address, rf_write_data, rf_read_en, rf_write_en,
    output rf_read_data, rf_access_complete, rf_invalid_address
  );
endinterface

// File: rtl/openhmc_rf_arbiter.sv
// Round-robin arbiter sharing one openHMC register-file port between NUM_REQ
// requesters: one single-cycle strobe per grant, completion wait with timeout.
module openhmc_rf_arbiter #(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned HMC_RF_AWIDTH = 4,
  parameter int unsigned HMC_RF_WWIDTH = 64,
  parameter int unsigned HMC_RF_RWIDTH = 64,
  parameter int unsigned TIMEOUT_LOG   = 4
) (
  input  logic                               clk_hmc,
  input  logic                               res_n_hmc,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ*HMC_RF_AWIDTH-1:0]   req_address,
  input  logic [NUM_REQ*HMC_RF_WWIDTH-1:0]   req_write_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [HMC_RF_RWIDTH-1:0]           rsp_read_data,
  output logic                               rsp_invalid,
  output logic                               rsp_timeout,
  openhmc_rf_arbiter_if.master               rf,
  output logic                               err_stray_complete
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam logic [TIMEOUT_LOG-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                     state_q, state_d;
  logic [GW-1:0]              last_grant_q, last_grant_d;
  logic [GW-1:0]              grant_q, grant_d;
  logic                       cap_write_q, cap_write_d;
  logic [HMC_RF_AWIDTH-1:0]   addr_q, addr_d;
  logic [HMC_RF_WWIDTH-1:0]   wdata_q, wdata_d;
  logic                       rd_en_q, rd_en_d;
  logic                       wr_en_q, wr_en_d;
  logic [TIMEOUT_LOG-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]         rsp_valid_q, rsp_valid_d;
  logic [HMC_RF_RWIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                       rsp_inv_q, rsp_inv_d;
  logic                       rsp_to_q, rsp_to_d;
  logic                       err_q, err_d;

  logic [GW-1:0]              winner;
  logic                       win_found;
  logic [GW:0]                sum;

  // Scan requesters starting one past the last grant, wrapping at NUM_REQ.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    sum       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_grant_q} + (GW+1)'(k);
      if (sum >= (GW+1)'(NUM_REQ)) sum = sum - (GW+1)'(NUM_REQ);
      if (!win_found && req_valid[sum[GW-1:0]]) begin
        win_found = 1'b1;
        winner    = sum[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cap_write_d  = cap_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    cnt_d        = cnt_q;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    rsp_inv_d    = rsp_inv_q;
    rsp_to_d     = rsp_to_q;
    err_d        = err_q | (rf.rf_access_complete && (state_q != WAIT));
    req_ready    = '0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          // Gated by reset so no requester sees an accept while held in reset.
          req_ready[winner] = res_n_hmc;
          grant_d     = winner;
          cap_write_d = req_write[winner];
          addr_d      = req_address[winner*HMC_RF_AWIDTH +: HMC_RF_AWIDTH];
          wdata_d     = req_write_data[winner*HMC_RF_WWIDTH +: HMC_RF_WWIDTH];
          wr_en_d     = req_write[winner];
          rd_en_d     = !req_write[winner];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (rf.rf_access_complete) begin
          rsp_data_d           = cap_write_q ? '0 : rf.rf_read_data;
          rsp_inv_d            = rf.rf_invalid_address;
          rsp_to_d             = 1'b0;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = RESP;
        end else if (cnt_q == CNT_MAX) begin
          rsp_data_d           = '0;
          rsp_inv_d            = 1'b0;
          rsp_to_d             = 1'b1;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = RESP;
        end else begin
          cnt_d = cnt_q + TIMEOUT_LOG'(1);
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_REQ-1);
      grant_q      <= '0;
      cap_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_inv_q    <= 1'b0;
      rsp_to_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cap_write_q  <= cap_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_inv_q    <= rsp_inv_d;
      rsp_to_q     <= rsp_to_d;
      err_q        <= err_d;
    end
  end

  assign rf.rf_address       = addr_q;
  assign rf.rf_write_data    = wdata_q;
  assign rf.rf_read_en       = rd_en_q;
  assign rf.rf_write_en      = wr_en_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_read_data       = rsp_data_q;
  assign rsp_invalid         = rsp_inv_q;
  assign rsp_timeout         = rsp_to_q;
  assign err_stray_complete  = err_q;

endmodule

// File: tb/tb_openhmc_rf_arbiter.sv
// Directed bench for openhmc_rf_arbiter: read, invalid write, fairness,
// timeout, completion on the timeout limit, and reset during WAIT.
module tb_openhmc_rf_arbiter;
  localparam int unsigned NR = 2;
  localparam int unsigned AW = 4;
  localparam int unsigned WW = 64;
  localparam int unsigned RW = 64;
  localparam int unsigned TL = 4;

  logic              clk_hmc = 1'b0;
  logic              res_n_hmc = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_write = '0;
  logic [NR*AW-1:0]  req_address = '0;
  logic [NR*WW-1:0]  req_write_data = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [RW-1:0]     rsp_read_data;
  logic              rsp_invalid;
  logic              rsp_timeout;
  logic              err_stray_complete;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk_hmc = ~clk_hmc;

  openhmc_rf_arbiter_if #(.AWIDTH(AW), .WWIDTH(WW), .RWIDTH(RW)) rf_if ();

  openhmc_rf_arbiter #(
    .NUM_REQ(NR), .HMC_RF_AWIDTH(AW), .HMC_RF_WWIDTH(WW),
    .HMC_RF_RWIDTH(RW), .TIMEOUT_LOG(TL)
  ) dut (
    .clk_hmc(clk_hmc),
    .res_n_hmc(res_n_hmc),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_address(req_address),
    .req_write_data(req_write_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_read_data(rsp_read_data),
    .rsp_invalid(rsp_invalid),
    .rsp_timeout(rsp_timeout),
    .rf(rf_if.master),
    .err_stray_complete(err_stray_complete)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_hmc);
    #1;
  endtask

  // Single-requester access with completion one cycle after the strobe.
  task automatic access(input int r, input bit wr, input logic [3:0] addr,
                        input logic [63:0] wd, input logic [63:0] rd,
                        input bit inv, input string tag);
    logic [NR-1:0] onehot;
    onehot = NR'(1) << r;
    req_valid = onehot;
    req_write = wr ? onehot : '0;
    req_address[r*AW +: AW] = addr;
    req_write_data[r*WW +: WW] = wd;
    #1 check({tag, " ready"}, req_ready, onehot);
    tick();
    req_valid = '0;
    check({tag, " rd_en"}, rf_if.rf_read_en, !wr);
    check({tag, " wr_en"}, rf_if.rf_write_en, wr);
    check({tag, " addr"}, rf_if.rf_address, addr);
    if (wr) check({tag, " wdata"}, rf_if.rf_write_data, wd);
    tick();
    check({tag, " strobes off"}, {rf_if.rf_read_en, rf_if.rf_write_en}, 0);
    rf_if.rf_access_complete = 1'b1;
    rf_if.rf_read_data       = rd;
    rf_if.rf_invalid_address = inv;
    tick();
    rf_if.rf_access_complete = 1'b0;
    rf_if.rf_invalid_address = 1'b0;
    check({tag, " rsp_valid"}, rsp_valid, onehot);
    check({tag, " rsp_data"}, rsp_read_data, wr ? 64'h0 : rd);
    check({tag, " rsp_invalid"}, rsp_invalid, inv);
    check({tag, " rsp_timeout"}, rsp_timeout, 0);
    tick();
    check({tag, " rsp_valid drop"}, rsp_valid, 0);
    check({tag, " rsp_data hold"}, rsp_read_data, wr ? 64'h0 : rd);
  endtask

  initial begin
    int unsigned cnt;
    rf_if.rf_read_data       = '0;
    rf_if.rf_access_complete = 1'b0;
    rf_if.rf_invalid_address = 1'b0;

    repeat (3) @(posedge clk_hmc);
    #1;
    check("reset rsp_valid", rsp_valid, 0);
    check("reset strobes", {rf_if.rf_read_en, rf_if.rf_write_en}, 0);
    check("reset addr", rf_if.rf_address, 0);
    check("reset err", err_stray_complete, 0);
    check("reset rsp_data", rsp_read_data, 0);
    res_n_hmc = 1'b1;
    tick();

    access(0, 1'b0, 4'h2, 64'h0, 64'hDEAD_BEEF, 1'b0, "read");
    rf_if.rf_read_data = 64'hFFFF_FFFF_FFFF_FFFF;
    access(1, 1'b1, 4'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "inv write");

    // Both requesters held valid: grants must alternate 0,1,0,1.
    req_valid      = '1;
    req_write      = 2'b10;
    req_address    = {4'h9, 4'h5};
    req_write_data = {64'hAAAA, 64'h0};
    for (int n = 0; n < 4; n++) begin
      int unsigned g;
      g = n % 2;
      #1 check("fair ready", req_ready, 64'(1) << g);
      tick();
      check("fair rd_en", rf_if.rf_read_en, g == 0);
      check("fair wr_en", rf_if.rf_write_en, g == 1);
      check("fair excl", rf_if.rf_read_en & rf_if.rf_write_en, 0);
      check("fair addr", rf_if.rf_address, (g == 1) ? 64'h9 : 64'h5);
      check("fair no ready", req_ready, 0);
      tick();
      rf_if.rf_access_complete = 1'b1;
      rf_if.rf_read_data       = 64'h100 + 64'(n);
      tick();
      rf_if.rf_access_complete = 1'b0;
      check("fair rsp_valid", rsp_valid, 64'(1) << g);
      check("fair rsp_data", rsp_read_data, (g == 0) ? (64'h100 + 64'(n)) : 64'h0);
      tick();
    end
    req_valid = '0;

    // Timeout: RF never completes.
    req_valid = 2'b01;
    req_write = '0;
    req_address[3:0] = 4'h3;
    #1 check("to ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    check("to rd_en", rf_if.rf_read_en, 1);
    cnt = 0;
    while (rsp_valid == '0 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("to latency", cnt, 17);
    check("to rsp_valid", rsp_valid, 2'b01);
    check("to rsp_timeout", rsp_timeout, 1);
    check("to rsp_invalid", rsp_invalid, 0);
    check("to rsp_data", rsp_read_data, 0);
    tick();
    check("to err before", err_stray_complete, 0);
    rf_if.rf_access_complete = 1'b1;
    tick();
    rf_if.rf_access_complete = 1'b0;
    check("to err stray", err_stray_complete, 1);
    check("to stray no rsp", rsp_valid, 0);

    // Completion on the same cycle the counter hits its limit.
    req_valid = 2'b10;
    req_write = '0;
    req_address[7:4] = 4'h7;
    #1 check("bnd ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    check("bnd rd_en", rf_if.rf_read_en, 1);
    repeat (16) tick();
    check("bnd no early rsp", rsp_valid, 0);
    rf_if.rf_access_complete = 1'b1;
    rf_if.rf_read_data       = 64'h1234_5678_9ABC_DEF0;
    tick();
    rf_if.rf_access_complete = 1'b0;
    check("bnd rsp_valid", rsp_valid, 2'b10);
    check("bnd rsp_timeout", rsp_timeout, 0);
    check("bnd rsp_data", rsp_read_data, 64'h1234_5678_9ABC_DEF0);
    check("bnd err sticky", err_stray_complete, 1);
    tick();

    // Make requester 0 the last grant, then abandon a requester-1 access.
    access(0, 1'b0, 4'hC, 64'h0, 64'h55, 1'b0, "pre");
    req_valid = 2'b10;
    req_write = '0;
    req_address[7:4] = 4'hE;
    #1 check("rst ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    tick();
    tick();
    res_n_hmc = 1'b0;
    #1;
    check("rst rsp_valid", rsp_valid, 0);
    check("rst strobes", {rf_if.rf_read_en, rf_if.rf_write_en}, 0);
    check("rst addr", rf_if.rf_address, 0);
    check("rst rsp_data", rsp_read_data, 0);
    check("rst err", err_stray_complete, 0);
    req_valid = 2'b01;
    #1 check("rst held ready", req_ready, 0);
    req_valid = '0;
    tick();
    tick();
    #2 res_n_hmc = 1'b1;
    tick();
    rf_if.rf_access_complete = 1'b1;
    tick();
    rf_if.rf_access_complete = 1'b0;
    check("rst late err", err_stray_complete, 1);
    cnt = 0;
    repeat (4) begin
      if (rsp_valid != '0) cnt++;
      tick();
    end
    check("rst no rsp", cnt, 0);
    req_valid = 2'b11;
    #1 check("rst priority", req_ready, 2'b01);
    tick();
    req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
